// File: rtl/freecell_pkg.sv
// Shared types and constants for the FreeCell engine: card layout, suits,
// ranks, location encoding of move endpoints and the engine state machine.
package freecell_pkg;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  localparam logic [1:0] SPADE   = 2'd0;
  localparam logic [1:0] CLUB    = 2'd1;
  localparam logic [1:0] HEART   = 2'd2;
  localparam logic [1:0] DIAMOND = 2'd3;

  localparam logic [3:0] ACE   = 4'd1;
  localparam logic [3:0] KING  = 4'd13;

  localparam card_t EMPTY_CARD = card_t'(6'b000000);

  // Location encoding: 0ccc = column, 10ff = free cell, 11xx = home.
  localparam logic       LOC_COL  = 1'b0;
  localparam logic [1:0] LOC_FREE = 2'b10;
  localparam logic [1:0] LOC_HOME = 2'b11;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    PLAY   = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    WON    = 3'd4
  } state_t;

  // Red suits (hearts, diamonds) have the upper suit bit set.
  function automatic logic card_red(input card_t c);
    return c.suit[1];
  endfunction

endpackage

// File: rtl/freecell_column.sv
// One tableau column: a fixed array plus height counter. Cards never shift;
// the top card is entry[height-1]. Push on a full column and pop on an
// empty column are ignored.
module freecell_column
  import freecell_pkg::*;
#(
  parameter int COL_DEPTH = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  card_t                          push_card,
  input  logic                           pop,
  output card_t                          top,
  output logic [$clog2(COL_DEPTH+1)-1:0] height,
  output logic                           full,
  output logic                           empty
);

  localparam int HGT_W = $clog2(COL_DEPTH + 1);
  localparam int IDX_W = $clog2(COL_DEPTH);

  card_t            mem_q [COL_DEPTH];
  card_t            mem_d [COL_DEPTH];
  logic [HGT_W-1:0] height_q;
  logic [HGT_W-1:0] height_d;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  assign full     = (height_q == HGT_W'(COL_DEPTH));
  assign empty    = (height_q == '0);
  assign wr_idx_s = height_q[IDX_W-1:0];
  assign rd_idx_s = wr_idx_s - IDX_W'(1);
  assign top      = empty ? EMPTY_CARD : mem_q[rd_idx_s];
  assign height   = height_q;

  // Next-state of the stack: write above the top on push, shrink on pop.
  always_comb begin
    mem_d    = mem_q;
    height_d = height_q;
    if (push && !full) begin
      mem_d[wr_idx_s] = push_card;
      height_d        = height_q + HGT_W'(1);
    end else if (pop && !empty) begin
      height_d = height_q - HGT_W'(1);
    end else begin
      height_d = height_q;
    end
  end

  // Stack registers with synchronous reset to an empty column.
  always_ff @(posedge clk) begin
    if (rst) begin
      height_q <= '0;
      mem_q    <= '{default: EMPTY_CARD};
    end else begin
      height_q <= height_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/freecell_engine.sv
// FreeCell engine: deal loading, one move per handshake (accept, CHECK,
// COMMIT), legality reporting, saturating move counter and sticky win.
module freecell_engine
  import freecell_pkg::*;
#(
  parameter int NUM_COLS  = 8,
  parameter int NUM_FREE  = 4,
  parameter int COL_DEPTH = 20,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [2:0]       load_col,
  input  logic [5:0]       load_card,
  input  logic             load_done,
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [3:0]       source,
  input  logic [3:0]       dest,
  output logic             move_done,
  output logic             illegal,
  output logic             win,
  output logic [CNT_W-1:0] move_count
);

  localparam int               HGT_W      = $clog2(COL_DEPTH + 1);
  localparam logic [HGT_W-1:0] HGT_FULL   = HGT_W'(COL_DEPTH);
  localparam logic [3:0]       NUM_COLS_V = 4'(NUM_COLS);
  localparam logic [2:0]       NUM_FREE_V = 3'(NUM_FREE);

  state_t           state_q, state_d;
  logic [3:0]       src_q, src_d, dst_q, dst_d;
  card_t            src_card_q, src_card_d;
  logic             legal_q, legal_d;
  card_t            free_q [4];
  card_t            free_d [4];
  logic [3:0]       home_q [4];
  logic [3:0]       home_d [4];
  logic             move_ready_q, move_ready_d;
  logic             move_done_q, move_done_d;
  logic             illegal_q, illegal_d;
  logic             win_q, win_d;
  logic [CNT_W-1:0] move_count_q, move_count_d;

  // Column array is padded to the full 3-bit index range; unused slots read
  // as empty and full so any column number can be decoded safely.
  logic             col_push_s  [8];
  logic             col_pop_s   [8];
  card_t            col_top_s   [8];
  logic [HGT_W-1:0] col_hgt_s   [8];
  logic             col_full_s  [8];
  logic             col_empty_s [8];
  card_t            push_card_s;

  card_t            chk_src_card_s;
  card_t            chk_dst_top_s;
  logic             chk_dst_ok_s;
  logic             chk_legal_s;

  for (genvar c = 0; c < 8; c++) begin : g_col
    if (c < NUM_COLS) begin : g_real
      freecell_column #(
        .COL_DEPTH(COL_DEPTH)
      ) u_col (
        .clk      (clk),
        .rst      (rst),
        .push     (col_push_s[c]),
        .push_card(push_card_s),
        .pop      (col_pop_s[c]),
        .top      (col_top_s[c]),
        .height   (col_hgt_s[c]),
        .full     (col_full_s[c]),
        .empty    (col_empty_s[c])
      );
    end else begin : g_none
      assign col_top_s[c]   = EMPTY_CARD;
      assign col_hgt_s[c]   = HGT_FULL;
      assign col_full_s[c]  = 1'b1;
      assign col_empty_s[c] = 1'b1;
    end
  end

  // Legality of the latched move, evaluated from the current storage.
  always_comb begin
    chk_src_card_s = EMPTY_CARD;
    chk_dst_top_s  = EMPTY_CARD;
    chk_dst_ok_s   = 1'b0;
    if (src_q[3] == LOC_COL) begin
      if ({1'b0, src_q[2:0]} < NUM_COLS_V) begin
        chk_src_card_s = col_top_s[src_q[2:0]];
      end else begin
        chk_src_card_s = EMPTY_CARD;
      end
    end else if (src_q[3:2] == LOC_FREE) begin
      if ({1'b0, src_q[1:0]} < NUM_FREE_V) begin
        chk_src_card_s = free_q[src_q[1:0]];
      end else begin
        chk_src_card_s = EMPTY_CARD;
      end
    end else begin
      chk_src_card_s = EMPTY_CARD;
    end

    if (dst_q[3] == LOC_COL) begin
      chk_dst_top_s = col_top_s[dst_q[2:0]];
      if (({1'b0, dst_q[2:0]} < NUM_COLS_V) && (col_hgt_s[dst_q[2:0]] != HGT_FULL)) begin
        chk_dst_ok_s = col_empty_s[dst_q[2:0]] ||
                       ((chk_dst_top_s.rank == chk_src_card_s.rank + 4'd1) &&
                        (card_red(chk_dst_top_s) != card_red(chk_src_card_s)));
      end else begin
        chk_dst_ok_s = 1'b0;
      end
    end else if (dst_q[3:2] == LOC_FREE) begin
      if ({1'b0, dst_q[1:0]} < NUM_FREE_V) begin
        chk_dst_ok_s = (free_q[dst_q[1:0]] == EMPTY_CARD);
      end else begin
        chk_dst_ok_s = 1'b0;
      end
    end else begin
      chk_dst_ok_s = (home_q[chk_src_card_s.suit] == chk_src_card_s.rank - 4'd1);
    end

    chk_legal_s = (chk_src_card_s != EMPTY_CARD) && (src_q != dst_q) && chk_dst_ok_s;
  end

  // Engine sequencing: loading, move accept, check, commit and win.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    src_card_d   = src_card_q;
    legal_d      = legal_q;
    free_d       = free_q;
    home_d       = home_q;
    move_done_d  = 1'b0;
    illegal_d    = illegal_q;
    win_d        = win_q;
    move_count_d = move_count_q;
    col_push_s   = '{default: 1'b0};
    col_pop_s    = '{default: 1'b0};
    push_card_s  = EMPTY_CARD;

    case (state_q)
      LOAD: begin
        if (load_valid) begin
          if (({1'b0, load_col} < NUM_COLS_V) && !col_full_s[load_col]) begin
            col_push_s[load_col] = 1'b1;
            push_card_s          = card_t'(load_card);
            illegal_d            = 1'b0;
          end else begin
            illegal_d = 1'b1;
          end
        end else begin
          illegal_d = illegal_q;
        end
        if (load_done) begin
          state_d = PLAY;
        end else begin
          state_d = LOAD;
        end
      end
      PLAY: begin
        if (move_valid && move_ready_q) begin
          src_d   = source;
          dst_d   = dest;
          state_d = CHECK;
        end else begin
          state_d = PLAY;
        end
      end
      CHECK: begin
        legal_d    = chk_legal_s;
        src_card_d = chk_src_card_s;
        state_d    = COMMIT;
      end
      COMMIT: begin
        move_done_d = 1'b1;
        illegal_d   = ~legal_q;
        state_d     = PLAY;
        if (legal_q) begin
          if (src_q[3] == LOC_COL) begin
            col_pop_s[src_q[2:0]] = 1'b1;
          end else begin
            free_d[src_q[1:0]] = EMPTY_CARD;
          end
          if (dst_q[3] == LOC_COL) begin
            col_push_s[dst_q[2:0]] = 1'b1;
            push_card_s            = src_card_q;
          end else if (dst_q[3:2] == LOC_FREE) begin
            free_d[dst_q[1:0]] = src_card_q;
          end else begin
            home_d[src_card_q.suit] = home_q[src_card_q.suit] + 4'd1;
          end
          if (move_count_q != {CNT_W{1'b1}}) begin
            move_count_d = move_count_q + CNT_W'(1);
          end else begin
            move_count_d = move_count_q;
          end
          if ((home_d[0] == KING) && (home_d[1] == KING) &&
              (home_d[2] == KING) && (home_d[3] == KING)) begin
            win_d   = 1'b1;
            state_d = WON;
          end else begin
            state_d = PLAY;
          end
        end else begin
          state_d = PLAY;
        end
      end
      WON: begin
        state_d = WON;
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    move_ready_d = (state_d == PLAY);
  end

  // Engine registers; reset aborts any in-flight move without committing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      src_q        <= 4'd0;
      dst_q        <= 4'd0;
      src_card_q   <= EMPTY_CARD;
      legal_q      <= 1'b0;
      free_q       <= '{default: EMPTY_CARD};
      home_q       <= '{default: 4'd0};
      move_ready_q <= 1'b0;
      move_done_q  <= 1'b0;
      illegal_q    <= 1'b0;
      win_q        <= 1'b0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      src_card_q   <= src_card_d;
      legal_q      <= legal_d;
      free_q       <= free_d;
      home_q       <= home_d;
      move_ready_q <= move_ready_d;
      move_done_q  <= move_done_d;
      illegal_q    <= illegal_d;
      win_q        <= win_d;
      move_count_q <= move_count_d;
    end
  end

  assign move_ready = move_ready_q;
  assign move_done  = move_done_q;
  assign illegal    = illegal_q;
  assign win        = win_q;
  assign move_count = move_count_q;

endmodule

// File: tb/tb_freecell_engine.sv
// Self-checking bench for freecell_engine: directed move table, load limits,
// reset during a move, a full winning game and randomized moves against a
// queue-based model of the game rules.
module tb_freecell_engine;

  localparam int NC    = 8;
  localparam int NF    = 4;
  localparam int DEPTH = 20;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [2:0]    load_col;
  logic [5:0]    load_card;
  logic          load_done;
  logic          move_valid;
  logic          move_ready;
  logic [3:0]    source;
  logic [3:0]    dest;
  logic          move_done;
  logic          illegal;
  logic          win;
  logic [CW-1:0] move_count;

  int checks = 0;
  int errors = 0;

  typedef logic [5:0] cq_t[$];
  cq_t        mcol [NC];
  logic [5:0] mfree [NF];
  int         mhome [4];
  int         mcount;

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    bit         ill;
    int         cnt;
  } vec_t;
  vec_t vt [20];

  always #5 clk = ~clk;

  freecell_engine #(
    .NUM_COLS(NC), .NUM_FREE(NF), .COL_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_col(load_col),
    .load_card(load_card), .load_done(load_done), .move_valid(move_valid),
    .move_ready(move_ready), .source(source), .dest(dest),
    .move_done(move_done), .illegal(illegal), .win(win),
    .move_count(move_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] mk(input int s, input int r);
    return {2'(s), 4'(r)};
  endfunction

  function automatic bit model_win();
    return (mhome[0] == 13) && (mhome[1] == 13) && (mhome[2] == 13) && (mhome[3] == 13);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mcol[i].delete();
    for (int i = 0; i < NF; i++) mfree[i] = 6'd0;
    for (int i = 0; i < 4; i++) mhome[i] = 0;
    mcount = 0;
  endtask

  // Apply the game rules to the model; returns whether the move is legal.
  task automatic model_move(input logic [3:0] s, input logic [3:0] d, output bit legal);
    logic [5:0] card;
    logic [5:0] t;
    int c;
    card = 6'd0;
    if (s[3] == 1'b0) begin
      c = int'(s[2:0]);
      if (c < NC && mcol[c].size() > 0) card = mcol[c][$];
    end else if (s[3:2] == 2'b10) begin
      if (int'(s[1:0]) < NF) card = mfree[s[1:0]];
    end
    legal = (card != 6'd0) && (s != d);
    if (legal) begin
      if (d[3] == 1'b0) begin
        c = int'(d[2:0]);
        if (c >= NC || mcol[c].size() >= DEPTH) legal = 1'b0;
        else if (mcol[c].size() > 0) begin
          t = mcol[c][$];
          legal = (int'(t[3:0]) == int'(card[3:0]) + 1) && (t[5] != card[5]);
        end
      end else if (d[3:2] == 2'b10) begin
        legal = (int'(d[1:0]) < NF) && (mfree[d[1:0]] == 6'd0);
      end else begin
        legal = (mhome[card[5:4]] == int'(card[3:0]) - 1);
      end
    end
    if (legal) begin
      if (s[3] == 1'b0) void'(mcol[s[2:0]].pop_back());
      else mfree[s[1:0]] = 6'd0;
      if (d[3] == 1'b0) mcol[d[2:0]].push_back(card);
      else if (d[3:2] == 2'b10) mfree[d[1:0]] = card;
      else mhome[card[5:4]]++;
      if (mcount < (1 << CW) - 1) mcount++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Load one card; expected drop status comes from the model.
  task automatic load_chk(input int c, input logic [5:0] card);
    bit exp_ill;
    exp_ill = (mcol[c].size() >= DEPTH);
    if (!exp_ill) mcol[c].push_back(card);
    load_valid = 1'b1;
    load_col   = 3'(c);
    load_card  = card;
    tick();
    load_valid = 1'b0;
    check("load_illegal", int'(illegal), int'(exp_ill));
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("ready_after_load", int'(move_ready), 1);
  endtask

  task automatic do_move(input logic [3:0] s, input logic [3:0] d, input bit exp_ill,
                         input int exp_cnt, input bit exp_win);
    int w;
    w = 0;
    while (!move_ready && w < 20) begin
      tick();
      w++;
    end
    if (!move_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: move_ready stayed 0 for %0d cycles", w);
      return;
    end
    move_valid = 1'b1;
    source     = s;
    dest       = d;
    tick();
    move_valid = 1'b0;
    check("ready_drop_n1", int'(move_ready), 0);
    check("done_early_n1", int'(move_done), 0);
    tick();
    check("done_early_n2", int'(move_done), 0);
    tick();
    check("move_done", int'(move_done), 1);
    check("move_illegal", int'(illegal), int'(exp_ill));
    check("move_count", int'(move_count), exp_cnt);
    check("win", int'(win), int'(exp_win));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit legal;
    logic [3:0] s;
    logic [3:0] d;
    int r;

    rst = 1'b1; load_valid = 1'b0; load_col = 3'd0; load_card = 6'd0;
    load_done = 1'b0; move_valid = 1'b0; source = 4'd0; dest = 4'd0;
    do_reset();
    check("rst_ready", int'(move_ready), 0);
    check("rst_done", int'(move_done), 0);
    check("rst_illegal", int'(illegal), 0);
    check("rst_win", int'(win), 0);
    check("rst_count", int'(move_count), 0);

    // Directed deal and move table.
    load_chk(0, mk(3, 6)); load_chk(0, mk(0, 4));
    load_chk(1, mk(2, 5));
    load_chk(2, mk(0, 5));
    load_chk(3, mk(1, 4));
    load_chk(4, mk(2, 13)); load_chk(4, mk(0, 2));
    load_chk(5, mk(0, 1));
    load_chk(6, mk(3, 9)); load_chk(6, mk(1, 8));
    finish_load();

    vt[0]  = '{4'h0, 4'h1, 1'b0, 1};
    vt[1]  = '{4'h3, 4'h2, 1'b1, 1};
    vt[2]  = '{4'h6, 4'h8, 1'b0, 2};
    vt[3]  = '{4'h6, 4'h8, 1'b1, 2};
    vt[4]  = '{4'h8, 4'hB, 1'b0, 3};
    vt[5]  = '{4'h9, 4'h0, 1'b1, 3};
    vt[6]  = '{4'h8, 4'hA, 1'b1, 3};
    vt[7]  = '{4'h4, 4'hC, 1'b1, 3};
    vt[8]  = '{4'h5, 4'hC, 1'b0, 4};
    vt[9]  = '{4'h4, 4'hC, 1'b0, 5};
    vt[10] = '{4'hC, 4'h0, 1'b1, 5};
    vt[11] = '{4'h4, 4'h4, 1'b1, 5};
    vt[12] = '{4'h2, 4'h8, 1'b0, 6};
    vt[13] = '{4'h4, 4'h2, 1'b0, 7};
    vt[14] = '{4'h3, 4'h0, 1'b1, 7};
    vt[15] = '{4'h3, 4'h5, 1'b0, 8};
    vt[16] = '{4'h0, 4'hF, 1'b1, 8};
    vt[17] = '{4'h1, 4'h0, 1'b1, 8};
    vt[18] = '{4'h8, 4'h0, 1'b0, 9};
    vt[19] = '{4'h1, 4'h0, 1'b1, 9};
    for (int i = 0; i < 20; i++) begin
      do_move(vt[i].src, vt[i].dst, vt[i].ill, vt[i].cnt, 1'b0);
    end

    // Column capacity: the 21st card is dropped, a good load clears illegal.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) load_chk(3, mk(i % 4, (i % 13) + 1));
    load_chk(4, mk(1, 7));
    finish_load();

    // Reset while the move is in COMMIT: nothing may commit.
    move_valid = 1'b1; source = 4'h3; dest = 4'h8;
    tick();
    move_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("abort_done", int'(move_done), 0);
    check("abort_count", int'(move_count), 0);
    check("abort_illegal", int'(illegal), 0);
    check("abort_ready", int'(move_ready), 0);

    // Winning game: column s holds suit s from king down to ace.
    for (int su = 0; su < 4; su++)
      for (int rk = 13; rk >= 1; rk--) load_chk(su, mk(su, rk));
    finish_load();
    for (int rk = 1; rk <= 13; rk++)
      for (int su = 0; su < 4; su++)
        do_move({1'b0, 3'(su)}, 4'hC, 1'b0, (rk - 1) * 4 + su + 1, (rk == 13) && (su == 3));
    check("won_ready", int'(move_ready), 0);
    seen = 0;
    move_valid = 1'b1; source = 4'h0; dest = 4'h8;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (move_done) seen++;
    end
    move_valid = 1'b0;
    check("won_ignores_moves", seen, 0);
    check("won_sticky", int'(win), 1);
    do_reset();
    check("won_rst_win", int'(win), 0);
    check("won_rst_ready", int'(move_ready), 0);
    load_chk(0, mk(2, 1));
    finish_load();

    // Randomized deal and moves against the rule model.
    do_reset();
    for (int i = 0; i < 40; i++) load_chk(int'($urandom_range(0, 7)), mk($urandom_range(0, 3), $urandom_range(1, 13)));
    finish_load();
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) s = {1'b0, 3'($urandom_range(0, 7))};
      else if (r < 9) s = {2'b10, 2'($urandom_range(0, 3))};
      else s = {2'b11, 2'($urandom_range(0, 3))};
      r = int'($urandom_range(0, 9));
      if (r < 5) d = {1'b0, 3'($urandom_range(0, 7))};
      else if (r < 8) d = {2'b10, 2'($urandom_range(0, 3))};
      else d = {2'b11, 2'($urandom_range(0, 3))};
      model_move(s, d, legal);
      do_move(s, d, !legal, mcount, model_win());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
